qea: RTL and testbench

- Quantum emulation accelerator. Holds an n-qubit complex state vector in on-chip state RAM and runs a gate program stored in a context (ctx) RAM.
- The host loads the program and the initial state, pulses i_start, waits for o_complete, then reads the final state back.
- Sits under the host/bus bridge as the top compute block.

---
 rtl/qea_pkg.sv | 72 +++++++
 rtl/qea_cmul.sv | 31 +++
 rtl/qea.sv | 179 +++++++++++++++++
 tb/tb_qea.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qea_pkg.sv
// qea_pkg: shared constants, types and arithmetic helpers for the quantum
// emulation accelerator (qea).
//   - sizing localparams for the state and context RAMs
//   - instruction opcodes and header field positions
//   - Q2.30 ONE constant, packed complex amplitude type
//   - FSM state encoding
//   - sx/fit32 helpers; fit32 saturates when QEA_SAT_EN is defined,
//     otherwise it wraps in two's complement.
package qea_pkg;

   localparam int PE_NUM_WIDTH            = 2;
   localparam int PE_NUM                  = 4;
   localparam int DATA_WIDTH              = 32;
   localparam int MAX_QBIT_WIDTH          = 6;
   localparam int ALU_DATA_WIDTH          = DATA_WIDTH;
   localparam int STATE_DATA_WIDTH        = 2*DATA_WIDTH;
   localparam int STATE_ADDR_WIDTH        = 16;
   localparam int GATE_DATA_WIDTH         = 2*DATA_WIDTH;
   localparam int GATE_ADDR_WIDTH         = 6;
   localparam int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH;
   localparam int GATE_CONTEXT_ADDR_WIDTH = 16;
   localparam int NUM_FRAC_BIT            = 30;
   localparam int STATE_DEPTH             = 64;
   localparam int CTX_DEPTH               = 1024;

   localparam int ROW_WIDTH    = PE_NUM*STATE_DATA_WIDTH;
   localparam int STATE_ROW_AW = $clog2(STATE_DEPTH);
   localparam int CTX_AW       = $clog2(CTX_DEPTH);
   // amplitude index k = {row, lane}
   localparam int K_WIDTH      = STATE_ROW_AW + PE_NUM_WIDTH;
   localparam int K_IDX_WIDTH  = $clog2(K_WIDTH);

   localparam logic [3:0] OP_END = 4'd0;
   localparam logic [3:0] OP_U   = 4'd1;
   localparam logic [3:0] OP_CU  = 4'd2;

   localparam int OP_MSB  = 63;
   localparam int OP_LSB  = 60;
   localparam int TGT_MSB = 59;
   localparam int TGT_LSB = 54;
   localparam int CTL_MSB = 53;
   localparam int CTL_LSB = 48;

   localparam logic signed [DATA_WIDTH-1:0] ONE = 32'sh4000_0000;

   typedef struct packed {
      logic signed [DATA_WIDTH-1:0] re;
      logic signed [DATA_WIDTH-1:0] im;
   } cplx_t;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOADM, S_SCAN, S_WR0, S_WR1, S_DONE
   } state_t;

   function automatic logic signed [2*DATA_WIDTH-1:0] sx(input logic signed [DATA_WIDTH-1:0] v);
      return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] fit32(input logic signed [2*DATA_WIDTH-1:0] v);
`ifdef QEA_SAT_EN
      if (v > sx(32'sh7FFF_FFFF))
         return 32'h7FFF_FFFF;
      else if (v < sx(32'sh8000_0000))
         return 32'h8000_0000;
      else
         return v[DATA_WIDTH-1:0];
`else
      return v[DATA_WIDTH-1:0];
`endif
   endfunction

endpackage

// File: rtl/qea_cmul.sv
// qea_cmul: combinational complex multiply p = a * b in Q2.30.
// Each real product is shifted right by NUM_FRAC_BIT and narrowed to
// DATA_WIDTH; the re/im sums are narrowed the same way. Narrowing wraps by
// default and saturates when QEA_SAT_EN is defined (see qea_pkg::fit32).
//   a, b : complex operands
//   p    : complex product
module qea_cmul
   import qea_pkg::*;
(
   input  cplx_t a,
   input  cplx_t b,
   output cplx_t p
);

   logic signed [2*DATA_WIDTH-1:0] rr, ii, ri, ir;
   logic signed [DATA_WIDTH-1:0]   rr_s, ii_s, ri_s, ir_s;

   always_comb begin
      rr   = sx(a.re) * sx(b.re);
      ii   = sx(a.im) * sx(b.im);
      ri   = sx(a.re) * sx(b.im);
      ir   = sx(a.im) * sx(b.re);
      rr_s = fit32(rr >>> NUM_FRAC_BIT);
      ii_s = fit32(ii >>> NUM_FRAC_BIT);
      ri_s = fit32(ri >>> NUM_FRAC_BIT);
      ir_s = fit32(ir >>> NUM_FRAC_BIT);
      p.re = fit32(sx(rr_s) - sx(ii_s));
      p.im = fit32(sx(ri_s) + sx(ir_s));
   end

endmodule

// File: rtl/qea.sv
// qea: quantum emulation accelerator top. Runs a gate program from the ctx
// RAM over an n-qubit state vector held in the state RAM.
//   clk, rst_n      : clock; rst_n is an asynchronous ACTIVE-HIGH reset
//   i_start         : start pulse (accepted in IDLE/DONE), i_qbit_num = n
//   i_ctx_*         : host ctx RAM write port (IDLE/DONE only)
//   i_state_*       : host state RAM row port, write-first (IDLE/DONE only)
//   o_complete      : level, set when END is reached
//   o_state_dout    : registered row readout, lane 0 in the MSBs
// Build option: QEA_SAT_EN selects saturating arithmetic.
//
// state   | meaning
// IDLE    | waiting for start, host owns the RAMs
// FETCH   | decode header at PC
// LOADM   | load u00,u01,u10,u11 (4 words)
// SCAN    | walk k; on a qualifying k latch a0/a1
// WR0     | write a0' to amp[k]
// WR1     | write a1' to amp[k | 1<<t], advance k
// DONE    | program finished, host owns the RAMs
module qea
   import qea_pkg::*;
(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               i_start,
   input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
   input  logic                               i_ctx_en,
   input  logic                               i_ctx_wea,
   input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ctx_addr,
   input  logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_data,
   input  logic                               i_state_ena,
   input  logic                               i_state_wea,
   input  logic [STATE_ADDR_WIDTH-1:0]        i_state_addra,
   input  logic [ROW_WIDTH-1:0]               i_state_dina,
   output logic                               o_complete,
   output logic [ROW_WIDTH-1:0]               o_state_dout
);

   logic [GATE_CONTEXT_DATA_WIDTH-1:0]        ctx_ram   [CTX_DEPTH];
   // index [PE_NUM-1] is the MSB slice, so lane l lives at index ~l
   logic [PE_NUM-1:0][STATE_DATA_WIDTH-1:0]   state_ram [STATE_DEPTH];

   state_t                               state;
   logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   pc;
   logic [MAX_QBIT_WIDTH-1:0]            n_q;
   logic [K_IDX_WIDTH-1:0]               tgt, ctl;
   logic                                 is_cu, skip;
   logic [1:0]                           mcnt;
   logic [K_WIDTH-1:0]                   k;
   cplx_t                                mat [4];
   cplx_t                                a0, a1;

   logic                                 host_ok;
   logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_word;
   logic [3:0]                           op;
   logic [GATE_ADDR_WIDTH-1:0]           hdr_t, hdr_c;
   logic                                 gate_skip;
   logic [K_WIDTH-1:0]                   k1, kmax;
   logic                                 qual;
   cplx_t                                p00, p01, p10, p11, a0n, a1n;
   logic                                 unused_bits;

   assign unused_bits = ^{i_ctx_addr[GATE_CONTEXT_ADDR_WIDTH-1:CTX_AW],
                          i_state_addra[STATE_ADDR_WIDTH-1:STATE_ROW_AW]};

   assign host_ok   = (state == S_IDLE) || (state == S_DONE);
   assign ctx_word  = ctx_ram[pc[CTX_AW-1:0]];
   assign op        = ctx_word[OP_MSB:OP_LSB];
   assign hdr_t     = ctx_word[TGT_MSB:TGT_LSB];
   assign hdr_c     = ctx_word[CTL_MSB:CTL_LSB];
   assign gate_skip = (hdr_t >= n_q) ||
                      ((op == OP_CU) && ((hdr_c == hdr_t) || (hdr_c >= n_q)));

   assign k1   = k | (K_WIDTH'(1) << tgt);
   assign kmax = ~({K_WIDTH{1'b1}} << n_q);
   assign qual = !k[tgt] && (!is_cu || k[ctl]);

   qea_cmul u_c00 (.a(mat[0]), .b(a0), .p(p00));
   qea_cmul u_c01 (.a(mat[1]), .b(a1), .p(p01));
   qea_cmul u_c10 (.a(mat[2]), .b(a0), .p(p10));
   qea_cmul u_c11 (.a(mat[3]), .b(a1), .p(p11));

   always_comb begin
      a0n.re = fit32(sx(p00.re) + sx(p01.re));
      a0n.im = fit32(sx(p00.im) + sx(p01.im));
      a1n.re = fit32(sx(p10.re) + sx(p11.re));
      a1n.im = fit32(sx(p10.im) + sx(p11.im));
   end

   // RAM arrays carry no reset; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (host_ok && i_ctx_en && i_ctx_wea)
         ctx_ram[i_ctx_addr[CTX_AW-1:0]] <= i_ctx_data;
      if (host_ok && i_state_ena && i_state_wea)
         state_ram[i_state_addra[STATE_ROW_AW-1:0]] <= i_state_dina;
      else if (state == S_WR0)
         state_ram[k[K_WIDTH-1:PE_NUM_WIDTH]][~k[PE_NUM_WIDTH-1:0]] <= a0n;
      else if (state == S_WR1)
         state_ram[k1[K_WIDTH-1:PE_NUM_WIDTH]][~k1[PE_NUM_WIDTH-1:0]] <= a1n;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state        <= S_IDLE;
         pc           <= '0;
         n_q          <= '0;
         tgt          <= '0;
         ctl          <= '0;
         is_cu        <= 1'b0;
         skip         <= 1'b0;
         mcnt         <= '0;
         k            <= '0;
         a0           <= '0;
         a1           <= '0;
         for (int i = 0; i < 4; i++) mat[i] <= '0;
         o_complete   <= 1'b0;
         o_state_dout <= '0;
      end else begin
         if (host_ok && i_state_ena)
            o_state_dout <= i_state_wea ? i_state_dina
                                        : state_ram[i_state_addra[STATE_ROW_AW-1:0]];
         case (state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  state      <= S_FETCH;
                  o_complete <= 1'b0;
                  pc         <= '0;
                  n_q        <= i_qbit_num;
               end
            end
            S_FETCH: begin
               case (op)
                  OP_END: begin
                     state      <= S_DONE;
                     o_complete <= 1'b1;
                  end
                  OP_U, OP_CU: begin
                     tgt   <= hdr_t[K_IDX_WIDTH-1:0];
                     ctl   <= hdr_c[K_IDX_WIDTH-1:0];
                     is_cu <= (op == OP_CU);
                     skip  <= gate_skip;
                     mcnt  <= '0;
                     pc    <= pc + 1'b1;
                     state <= S_LOADM;
                  end
                  default: pc <= pc + 1'b1;
               endcase
            end
            S_LOADM: begin
               mat[mcnt] <= ctx_word;
               pc        <= pc + 1'b1;
               mcnt      <= mcnt + 1'b1;
               if (mcnt == 2'd3) begin
                  k     <= '0;
                  state <= skip ? S_FETCH : S_SCAN;
               end
            end
            S_SCAN: begin
               if (qual) begin
                  a0    <= state_ram[k[K_WIDTH-1:PE_NUM_WIDTH]][~k[PE_NUM_WIDTH-1:0]];
                  a1    <= state_ram[k1[K_WIDTH-1:PE_NUM_WIDTH]][~k1[PE_NUM_WIDTH-1:0]];
                  state <= S_WR0;
               end else if (k == kmax) begin
                  state <= S_FETCH;
               end else begin
                  k <= k + 1'b1;
               end
            end
            S_WR0: state <= S_WR1;
            // a qualifying k has bit t clear, so k < kmax here
            S_WR1: begin
               k     <= k + 1'b1;
               state <= S_SCAN;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qea.sv
module tb_qea;

   localparam logic [63:0] ONE64 = 64'h40000000_00000000;
   localparam logic [63:0] HP    = 64'h2D413CCD_00000000;
   localparam logic [63:0] HN    = 64'hD2BEC333_00000000;
   localparam logic [63:0] ZW    = 64'h0;
   localparam logic [63:0] IJ    = 64'h00000000_40000000;
   localparam logic [63:0] MONE  = 64'hC0000000_00000000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [5:0]   qbit_num;
   logic         ctx_en, ctx_wea;
   logic [15:0]  ctx_addr;
   logic [63:0]  ctx_data;
   logic         st_en, st_wea;
   logic [15:0]  st_addr;
   logic [255:0] st_din;
   logic         complete;
   logic [255:0] st_dout;

   always #5 clk = ~clk;

   qea dut (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_qbit_num(qbit_num),
      .i_ctx_en(ctx_en), .i_ctx_wea(ctx_wea), .i_ctx_addr(ctx_addr), .i_ctx_data(ctx_data),
      .i_state_ena(st_en), .i_state_wea(st_wea), .i_state_addra(st_addr),
      .i_state_dina(st_din), .o_complete(complete), .o_state_dout(st_dout)
   );

   int checks = 0;
   int errors = 0;

   int   rises = 0;
   logic comp_d = 1'b0;
   always @(negedge clk) begin
      if (complete && !comp_d) rises = rises + 1;
      comp_d = complete;
   end

   typedef struct {
      int           test;
      int           row;
      logic [255:0] exp;
   } rb_t;
   rb_t tab [18];

   logic [63:0] prog [$];

   function automatic logic [255:0] mkrow(input logic [63:0] l0, l1, l2, l3);
      return {l0, l1, l2, l3};
   endfunction

   function automatic logic [63:0] hdr(input logic [3:0] op, input logic [5:0] t, input logic [5:0] c);
      return {op, t, c, 48'h0};
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add_gate(input logic [3:0] op, input logic [5:0] t, input logic [5:0] c,
                           input logic [63:0] m0, m1, m2, m3);
      prog.push_back(hdr(op, t, c));
      prog.push_back(m0); prog.push_back(m1); prog.push_back(m2); prog.push_back(m3);
   endtask

   task automatic load_prog();
      for (int i = 0; i < prog.size(); i++) begin
         @(negedge clk);
         ctx_en = 1'b1; ctx_wea = 1'b1; ctx_addr = 16'(i); ctx_data = prog[i];
      end
      @(negedge clk);
      ctx_en = 1'b0; ctx_wea = 1'b0;
   endtask

   task automatic write_row(input int r, input logic [255:0] d);
      @(negedge clk);
      st_en = 1'b1; st_wea = 1'b1; st_addr = 16'(r); st_din = d;
      @(negedge clk);
      st_en = 1'b0; st_wea = 1'b0;
   endtask

   task automatic read_row(input int r, output logic [255:0] d);
      @(negedge clk);
      st_en = 1'b1; st_wea = 1'b0; st_addr = 16'(r);
      @(negedge clk);
      st_en = 1'b0;
      d = st_dout;
   endtask

   task automatic set_state(input logic [255:0] r0, r1, r2, r3);
      write_row(0, r0); write_row(1, r1); write_row(2, r2); write_row(3, r3);
   endtask

   task automatic do_start(input logic [5:0] n);
      @(negedge clk);
      start = 1'b1; qbit_num = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (!complete && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic check_tab(input int id);
      logic [255:0] d;
      for (int i = 0; i < 18; i++) begin
         if (tab[i].test == id) begin
            read_row(tab[i].row, d);
            chk($sformatf("t%0d_row%0d", id, tab[i].row), d, tab[i].exp);
         end
      end
   endtask

   task automatic run_and_check(input int id, input logic [5:0] n);
      int cyc;
      do_start(n);
      wait_done(5000, cyc);
      chk($sformatf("t%0d_done", id), 256'(complete), 256'(1));
      check_tab(id);
   endtask

   initial begin
      int           cyc;
      int           base;
      logic [255:0] d;
      logic [255:0] S0;

      S0 = mkrow(ONE64, ZW, ZW, ZW);
      tab[0]  = '{1, 0, S0};
      tab[1]  = '{1, 1, '0};
      tab[2]  = '{1, 2, '0};
      tab[3]  = '{1, 3, '0};
      tab[4]  = '{2, 0, mkrow(HP, HP, ZW, ZW)};
      tab[5]  = '{2, 1, '0};
      tab[6]  = '{3, 0, '0};
      tab[7]  = '{3, 2, S0};
      tab[8]  = '{4, 0, mkrow(HP, ZW, ZW, HP)};
      tab[9]  = '{4, 1, '0};
      tab[10] = '{5, 0, mkrow(64'hF0000000_20000000, ZW, 64'hF0000000_10000000, ZW)};
      tab[11] = '{6, 3, mkrow(ZW, ZW, ZW, ONE64)};
      tab[12] = '{6, 0, '0};
      tab[13] = '{6, 1, '0};
      tab[14] = '{6, 2, '0};
      tab[15] = '{7, 3, '0};
      tab[16] = '{7, 0, S0};
      tab[17] = '{8, 3, mkrow(ZW, ZW, ZW, ONE64)};

      rst_n = 1'b1; start = 1'b0; qbit_num = '0;
      ctx_en = 1'b0; ctx_wea = 1'b0; ctx_addr = '0; ctx_data = '0;
      st_en = 1'b0; st_wea = 1'b0; st_addr = '0; st_din = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset_complete", 256'(complete), 256'(0));
      chk("reset_dout", st_dout, '0);

      // T1: END only
      prog.delete();
      prog.push_back(hdr(4'd0, 6'd0, 6'd0));
      load_prog();
      set_state(S0, '0, '0, '0);
      do_start(6'd4);
      wait_done(10, cyc);
      chk("t1_done_in_10", 256'(complete), 256'(1));
      check_tab(1);

      // T2: Hadamard on t=0
      prog.delete();
      add_gate(4'd1, 6'd0, 6'd0, HP, HP, HP, HN);
      prog.push_back(hdr(4'd0, 6'd0, 6'd0));
      load_prog();
      set_state(S0, '0, '0, '0);
      run_and_check(2, 6'd4);

      // T3: X on t=3
      prog.delete();
      add_gate(4'd1, 6'd3, 6'd0, ZW, ONE64, ONE64, ZW);
      prog.push_back(hdr(4'd0, 6'd0, 6'd0));
      load_prog();
      set_state(S0, '0, '0, '0);
      run_and_check(3, 6'd4);

      // T4: H on t=0 then CNOT c=0 t=1
      prog.delete();
      add_gate(4'd1, 6'd0, 6'd0, HP, HP, HP, HN);
      add_gate(4'd2, 6'd1, 6'd0, ZW, ONE64, ONE64, ZW);
      prog.push_back(hdr(4'd0, 6'd0, 6'd0));
      load_prog();
      set_state(S0, '0, '0, '0);
      run_and_check(4, 6'd4);

      // T5: n=2, NOP, skipped U (t>=n), skipped CU (c==t), then complex phase gate on t=1
      prog.delete();
      prog.push_back(hdr(4'd3, 6'd0, 6'd0));
      add_gate(4'd1, 6'd2, 6'd0, ZW, ONE64, ONE64, ZW);
      add_gate(4'd2, 6'd1, 6'd1, ZW, ONE64, ONE64, ZW);
      add_gate(4'd1, 6'd1, 6'd0, IJ, ZW, ZW, MONE);
      prog.push_back(hdr(4'd0, 6'd0, 6'd0));
      load_prog();
      set_state(mkrow(64'h20000000_10000000, ZW, 64'h10000000_F0000000, ZW), '0, '0, '0);
      run_and_check(5, 6'd2);

      // T6: 52 X gates cycling t=0..3, then END (261 words)
      prog.delete();
      for (int g = 0; g < 52; g++)
         add_gate(4'd1, 6'(g % 4), 6'd0, ZW, ONE64, ONE64, ZW);
      prog.push_back(hdr(4'd0, 6'd0, 6'd0));
      chk("t6_prog_len", 256'(prog.size()), 256'(261));
      load_prog();
      set_state(S0, '0, '0, '0);
      base = rises;
      do_start(6'd4);
      repeat (10) @(negedge clk);
      st_en = 1'b1; st_wea = 1'b1; st_addr = 16'd1; st_din = '1;
      @(negedge clk);
      st_en = 1'b0; st_wea = 1'b0;
      wait_done(10000, cyc);
      chk("t6_done", 256'(complete), 256'(1));
      repeat (5) @(negedge clk);
      chk("t6_single_rise", 256'(rises - base), 256'(1));
      check_tab(6);

      // T7: rerun from DONE; complete must drop on the accepted start
      do_start(6'd4);
      chk("t7_complete_drop", 256'(complete), 256'(0));
      wait_done(10000, cyc);
      chk("t7_done", 256'(complete), 256'(1));
      check_tab(7);

      // reset during SCAN of the first gate
      read_row(0, d);
      do_start(6'd4);
      repeat (20) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_complete", 256'(complete), 256'(0));
      chk("midrst_dout", st_dout, '0);
      @(negedge clk);
      rst_n = 1'b0;
      set_state(S0, '0, '0, '0);
      read_row(0, d);
      chk("midrst_idle_host", d, S0);

      // T8: program still in ctx RAM, runs normally after reset
      run_and_check(8, 6'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
